// File: rtl/count_date.sv
// Day/month calendar stage: BCD day and month counters advanced by en_day or manual adjust.
// Define COUNT_DATE_LEAP_EN to let leap_year select a 29-day February; otherwise February is 28 days.
module count_date #(
   parameter int DIG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_day,
   input  logic             up,
   input  logic             down,
   input  logic             sel,
   input  logic             leap_year,
   output logic [DIG_W-1:0] day_unit,
   output logic [DIG_W-1:0] day_ten,
   output logic [DIG_W-1:0] mon_unit,
   output logic [DIG_W-1:0] mon_ten,
   output logic             en_yr
);

   logic [DIG_W-1:0] day_unit_q, day_ten_q, mon_unit_q, mon_ten_q;
   logic [DIG_W-1:0] day_unit_d, day_ten_d, mon_unit_d, mon_ten_d;
   logic             en_yr_q, en_yr_d;

   logic [4:0] day_cur, day_nxt, mlen_cur, mlen_nxt;
   logic [3:0] mon_cur, mon_nxt;
   logic       leap_eff;

`ifdef COUNT_DATE_LEAP_EN
   assign leap_eff = leap_year;
`else
   // leap_year stays on the port but cannot influence February in this build
   assign leap_eff = leap_year & 1'b0;
`endif

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      logic [4:0] len;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
         4'd2:                    len = leap ? 5'd29 : 5'd28;
         default:                 len = 5'd31;
      endcase
      return len;
   endfunction

   assign day_cur  = 5'(day_ten_q) * 5'd10 + 5'(day_unit_q);
   assign mon_cur  = 4'(mon_ten_q) * 4'd10 + 4'(mon_unit_q);
   assign mlen_cur = month_len(mon_cur, leap_eff);

   always_comb begin
      day_nxt  = day_cur;
      mon_nxt  = mon_cur;
      mlen_nxt = mlen_cur;
      en_yr_d  = 1'b0;
      if (en_day) begin
         // a day beyond the month length (leap flag dropped on 29/02) also rolls over
         if (day_cur < mlen_cur) begin
            day_nxt = day_cur + 5'd1;
         end else begin
            day_nxt = 5'd1;
            if (mon_cur == 4'd12) begin
               mon_nxt = 4'd1;
               en_yr_d = 1'b1;
            end else begin
               mon_nxt = mon_cur + 4'd1;
            end
         end
      end else if (up ^ down) begin
         if (!sel) begin
            if (up) begin
               day_nxt = (day_cur >= mlen_cur) ? 5'd1 : day_cur + 5'd1;
            end else begin
               day_nxt = (day_cur <= 5'd1) ? mlen_cur : day_cur - 5'd1;
            end
         end else begin
            if (up) begin
               mon_nxt = (mon_cur == 4'd12) ? 4'd1 : mon_cur + 4'd1;
            end else begin
               mon_nxt = (mon_cur == 4'd1) ? 4'd12 : mon_cur - 4'd1;
            end
            mlen_nxt = month_len(mon_nxt, leap_eff);
            if (day_cur > mlen_nxt) begin
               day_nxt = mlen_nxt;
            end
         end
      end
      day_ten_d  = DIG_W'(day_nxt / 5'd10);
      day_unit_d = DIG_W'(day_nxt % 5'd10);
      mon_ten_d  = DIG_W'(mon_nxt / 4'd10);
      mon_unit_d = DIG_W'(mon_nxt % 4'd10);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_unit_q <= DIG_W'(1);
         day_ten_q  <= '0;
         mon_unit_q <= DIG_W'(1);
         mon_ten_q  <= '0;
         en_yr_q    <= 1'b0;
      end else begin
         day_unit_q <= day_unit_d;
         day_ten_q  <= day_ten_d;
         mon_unit_q <= mon_unit_d;
         mon_ten_q  <= mon_ten_d;
         en_yr_q    <= en_yr_d;
      end
   end

   assign day_unit = day_unit_q;
   assign day_ten  = day_ten_q;
   assign mon_unit = mon_unit_q;
   assign mon_ten  = mon_ten_q;
   assign en_yr    = en_yr_q;

endmodule

// File: tb/tb_count_date.sv
// Self-checking bench for count_date: directed calendar cases then randomized
// stimulus compared against a day/month reference model.
module tb_count_date;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_day = 1'b0, up = 1'b0, down = 1'b0, sel = 1'b0, leap_year = 1'b0;
   logic [3:0] day_unit, day_ten, mon_unit, mon_ten;
   logic       en_yr;

   int vectors = 0;
   int miscompares = 0;

   int m_day = 1;
   int m_mon = 1;
   bit m_yr = 1'b0;

   count_date #(.DIG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .en_day(en_day), .up(up), .down(down),
      .sel(sel), .leap_year(leap_year),
      .day_unit(day_unit), .day_ten(day_ten), .mon_unit(mon_unit), .mon_ten(mon_ten),
      .en_yr(en_yr)
   );

   always #5 clk = ~clk;

   function automatic int month_days(input int m, input bit leap);
      int t[12];
      int r;
      t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      r = t[m-1];
`ifdef COUNT_DATE_LEAP_EN
      if (m == 2 && leap) r = 29;
`endif
      return r;
   endfunction

   function automatic logic [15:0] exp_date(input int d, input int m);
      return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      checkOutput({tag, "/date"}, 32'({day_ten, day_unit, mon_ten, mon_unit}), 32'(exp_date(m_day, m_mon)));
      checkOutput({tag, "/en_yr"}, 32'(en_yr), 32'(m_yr));
   endtask

   // Drive one cycle of inputs, advance the model by the calendar rules, check after the edge
   task automatic applyStimulus(input bit e, input bit u, input bit d, input bit s, input bit l,
                                input string tag);
      int len, nl;
      en_day = e; up = u; down = d; sel = s; leap_year = l;
      len  = month_days(m_mon, l);
      m_yr = 1'b0;
      if (e) begin
         if (m_day < len) m_day++;
         else begin
            m_day = 1;
            if (m_mon == 12) begin m_mon = 1; m_yr = 1'b1; end
            else m_mon++;
         end
      end else if (u != d) begin
         if (!s) begin
            if (u) m_day = (m_day >= len) ? 1 : m_day + 1;
            else   m_day = (m_day <= 1) ? len : m_day - 1;
         end else begin
            m_mon = u ? (m_mon % 12) + 1 : ((m_mon + 10) % 12) + 1;
            nl = month_days(m_mon, l);
            if (m_day > nl) m_day = nl;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      m_day = 1; m_mon = 1; m_yr = 1'b0;
      check_all(tag);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 0, 1, 1, 0, "mon_dn_wrap");
      applyStimulus(0, 0, 1, 0, 0, "day_dn_31dec");
      applyStimulus(1, 0, 0, 0, 0, "year_wrap");
      applyStimulus(0, 0, 0, 0, 0, "yr_one_cycle");
      applyStimulus(0, 0, 1, 0, 0, "day_dn_31jan");
      applyStimulus(0, 1, 0, 1, 0, "clamp_feb_noleap");
      applyStimulus(0, 0, 1, 1, 0, "feb_to_jan");
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, "day_up_to_31");
      applyStimulus(0, 1, 0, 1, 1, "clamp_feb_leap");
      applyStimulus(1, 0, 0, 0, 1, "feb_end_roll");
      applyStimulus(0, 0, 1, 0, 1, "day_dn_31mar");
      applyStimulus(0, 0, 1, 1, 1, "mar_dn_clamp");
      applyStimulus(0, 0, 1, 1, 1, "to_jan");
      applyStimulus(0, 1, 0, 1, 1, "to_feb");
      applyStimulus(0, 0, 1, 0, 1, "feb_day_dn");
      applyStimulus(1, 0, 0, 0, 1, "leap_step1");
      applyStimulus(1, 0, 0, 0, 1, "leap_step2");
      applyStimulus(0, 0, 1, 0, 0, "day_dn_31mar_b");
      applyStimulus(0, 1, 0, 1, 0, "apr_clamp");
      applyStimulus(0, 1, 1, 0, 0, "hold_both");
      applyStimulus(1, 1, 0, 0, 0, "en_day_priority");
      applyStimulus(1, 0, 0, 0, 0, "en_day_plain");
      async_reset("reset_mid");

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            async_reset("rand_reset");
         end else begin
            applyStimulus($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
